inv_key_schedule: RTL and testbench

//  Reverse-direction AES-128 key schedule for the decryption datapath. Loads the round-10 key and

---
 rtl/inv_key_schedule_pkg.sv | 76 +++++++
 rtl/inv_key_schedule_subword.sv | 40 ++++
 rtl/inv_key_schedule.sv | 159 +++++++++++++++
 tb/tb_inv_key_schedule.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/inv_key_schedule_pkg.sv
// Shared AES key-schedule definitions: round constants, FSM state type, and the
// word/byte helpers used by the inverse key schedule and the S-box.
package inv_key_schedule_pkg;

  localparam int NR    = 10;
  localparam int KEY_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SUB  = 2'd2,
    COMB = 2'd3
  } ks_state_t;

  localparam logic [7:0] RCON [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] v;
    if (r <= 4'd10) v = RCON[r];
    else            v = 8'h00;
    return v;
  endfunction

  function automatic logic [31:0] rotword(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Undo the chained XOR of words 1..3; word 0 still needs the SubWord/RCON term.
  function automatic logic [127:0] unmix_words(input logic [127:0] k);
    return {k[127:96],
            k[95:64] ^ k[127:96],
            k[63:32] ^ k[95:64],
            k[31:0]  ^ k[63:32]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      else      p = p;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; zero maps to zero naturally.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    return gmul(x252, x2);
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/inv_key_schedule_subword.sv
// SubWord with a registered (1-cycle) S-box per byte; shared with the forward
// key expansion.
module sbox_sync
  import inv_key_schedule_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // registered S-box lookup, updated only when enabled
  always_ff @(posedge clk) begin
    if (!reset)  dout <= 8'h00;
    else if (en) dout <= sbox_fwd(din);
    else         dout <= dout;
  end

endmodule

module subword_sync (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sbox_sync u_sbox (
      .clk  (clk),
      .reset(reset),
      .en   (en),
      .din  (din[8*g +: 8]),
      .dout (dout[8*g +: 8])
    );
  end

endmodule

// File: rtl/inv_key_schedule.sv
// Reverse AES-128 key schedule: loads rk10 and emits rk10..rk0, two cycles per step.
// Optional KEY_STORE_EN adds an 11-entry store of the emitted keys with a read port.
module inv_key_schedule
  import inv_key_schedule_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] lastkey,
  output logic [KEY_W-1:0] rkey,
  output logic [3:0]       round,
  output logic             rkey_valid,
  output logic             busy,
  output logic             done
`ifdef KEY_STORE_EN
  ,
  input  logic [3:0]       rd_idx,
  output logic [KEY_W-1:0] rd_key
`endif
);

  ks_state_t        state_r, next_state_s;
  logic [KEY_W-1:0] key_hold_r;
  logic [KEY_W-1:0] rkey_r;
  logic [3:0]       round_r;
  logic             valid_r, busy_r, done_r;

  logic             capture_s, load_s, step_s, sub_en_s;
  logic             valid_s, busy_s, done_s;
  logic [KEY_W-1:0] mixed_s, prev_key_s;
  logic [31:0]      sub_in_s, sub_out_s;

  assign mixed_s    = unmix_words(rkey_r);
  assign sub_in_s   = rotword(mixed_s[31:0]);
  assign prev_key_s = {mixed_s[127:96] ^ sub_out_s ^ {rcon_of(round_r), 24'h000000},
                       mixed_s[95:0]};

  subword_sync u_subword (
    .clk  (clk),
    .reset(reset),
    .en   (sub_en_s),
    .din  (sub_in_s),
    .dout (sub_out_s)
  );

  // next-state and per-cycle control decode
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    load_s       = 1'b0;
    step_s       = 1'b0;
    sub_en_s     = 1'b0;
    valid_s      = 1'b0;
    busy_s       = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = LOAD;
          capture_s    = 1'b1;
          busy_s       = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: begin
        next_state_s = SUB;
        load_s       = 1'b1;
        valid_s      = 1'b1;
        busy_s       = 1'b1;
      end
      SUB: begin
        next_state_s = COMB;
        sub_en_s     = 1'b1;
        busy_s       = 1'b1;
      end
      COMB: begin
        step_s  = 1'b1;
        valid_s = 1'b1;
        // round_r is never below 1 here, so the step cannot wrap
        if (round_r == 4'd1) begin
          next_state_s = IDLE;
          done_s       = 1'b1;
        end else begin
          next_state_s = SUB;
          busy_s       = 1'b1;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // state, key datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      key_hold_r <= '0;
      rkey_r     <= '0;
      round_r    <= 4'd0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r <= next_state_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      if (capture_s) key_hold_r <= lastkey;
      else           key_hold_r <= key_hold_r;
      if (load_s) begin
        rkey_r  <= key_hold_r;
        round_r <= 4'(NR);
      end else if (step_s) begin
        rkey_r  <= prev_key_s;
        round_r <= round_r - 4'd1;
      end else begin
        rkey_r  <= rkey_r;
        round_r <= round_r;
      end
    end
  end

  assign rkey       = rkey_r;
  assign round      = round_r;
  assign rkey_valid = valid_r;
  assign busy       = busy_r;
  assign done       = done_r;

`ifdef KEY_STORE_EN
  logic [KEY_W-1:0] store_r [0:10];
  logic             complete_r;

  // store each emitted key at its round index
  always_ff @(posedge clk) begin
    for (int i = 0; i <= NR; i++) begin
      if (reset && load_s && (i == NR))                         store_r[i] <= key_hold_r;
      else if (reset && step_s && (4'(i) == round_r - 4'd1))    store_r[i] <= prev_key_s;
      else                                                      store_r[i] <= store_r[i];
    end
  end

  // the store reads as zero until a full sequence has finished since reset
  always_ff @(posedge clk) begin
    if (!reset)      complete_r <= 1'b0;
    else if (done_s) complete_r <= 1'b1;
    else             complete_r <= complete_r;
  end

  // combinational read port
  always_comb begin
    rd_key = '0;
    if (complete_r && (rd_idx <= 4'(NR))) rd_key = store_r[rd_idx];
    else                                  rd_key = '0;
  end
`endif

endmodule

// File: tb/tb_inv_key_schedule.sv
// Scoreboard bench for inv_key_schedule: expected keys queued at start, popped on rkey_valid.
module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] lastkey;
  logic [127:0] rkey;
  logic [3:0]   round;
  logic         rkey_valid;
  logic         busy;
  logic         done;
`ifdef KEY_STORE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
`endif

  always #5 clk = ~clk;

  inv_key_schedule dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .lastkey   (lastkey),
    .rkey      (rkey),
    .round     (round),
    .rkey_valid(rkey_valid),
    .busy      (busy),
    .done      (done)
`ifdef KEY_STORE_EN
    ,
    .rd_idx    (rd_idx),
    .rd_key    (rd_key)
`endif
  );

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
    bit           chk_key;
    int           edge_no;
    bit           dn;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad   = 0;
  logic [127:0] fips    [0:10];
  logic [127:0] exp_key [0:10];
  bit           exp_chk [0:10];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_run();
    exp_t x;
    for (int r = 10; r >= 0; r--) begin
      x.rnd     = 4'(r);
      x.key     = exp_key[r];
      x.chk_key = exp_chk[r];
      x.edge_no = 1 + 2 * (10 - r);
      x.dn      = (r == 0);
      sb.push_back(x);
    end
  endtask

  // Caller has already raised start; edge 0 is the next rising edge.
  task automatic run_seq(input int ex1, input int ex2, input int abort_e, input int last_e,
                         input bit chain, input logic [127:0] next_key);
    exp_t         x;
    logic [127:0] last_k;
    logic [3:0]   last_r;
    bit           seen;
    bit           aborted;
    seen    = 1'b0;
    aborted = 1'b0;
    last_k  = '0;
    last_r  = 4'd0;
    @(posedge clk); #1; start = 1'b0;
    for (int e = 1; e <= last_e; e++) begin
      if (e == ex1 || e == ex2) start = 1'b1;
      if (e == abort_e) reset = 1'b0;
      @(posedge clk); #1; start = 1'b0;
      if (e == abort_e) begin
        chk("rst_rkey", rkey, 128'h0);
        chk("rst_round", {124'h0, round}, 128'h0);
        chk("rst_valid", {127'h0, rkey_valid}, 128'h0);
        chk("rst_busy", {127'h0, busy}, 128'h0);
        chk("rst_done", {127'h0, done}, 128'h0);
        reset   = 1'b1;
        aborted = 1'b1;
        sb.delete();
        break;
      end
      chk("busy", {127'h0, busy}, {127'h0, (e < 21)});
      if (rkey_valid) begin
        chk("pulse_expected", {127'h0, (sb.size() > 0)}, 128'h1);
        if (sb.size() > 0) begin
          x = sb.pop_front();
          chk("round", {124'h0, round}, {124'h0, x.rnd});
          if (x.chk_key) chk($sformatf("rk%0d", x.rnd), rkey, x.key);
          chk("pulse_edge", 128'(e), 128'(x.edge_no));
          chk("done_at_pulse", {127'h0, done}, {127'h0, x.dn});
        end
        last_k = rkey;
        last_r = round;
        seen   = 1'b1;
      end else begin
        chk("done_no_pulse", {127'h0, done}, 128'h0);
        if (seen) begin
          chk("rkey_hold", rkey, last_k);
          chk("round_hold", {124'h0, round}, {124'h0, last_r});
        end
      end
    end
    if (aborted) begin
`ifdef KEY_STORE_EN
      rd_idx = 4'd5;
      #1;
      chk("store_after_reset", rd_key, 128'h0);
`endif
      repeat (4) begin
        @(posedge clk); #1;
        chk("post_rst_valid", {127'h0, rkey_valid}, 128'h0);
        chk("post_rst_busy", {127'h0, busy}, 128'h0);
      end
    end else begin
      chk("pulses_left", 128'(sb.size()), 128'h0);
    end
    if (chain) begin
      start   = 1'b1;
      lastkey = next_key;
    end
  endtask

  initial begin
    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    reset   = 1'b0;
    start   = 1'b0;
    lastkey = '0;
`ifdef KEY_STORE_EN
    rd_idx  = 4'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rkey", rkey, 128'h0);
    chk("reset_round", {124'h0, round}, 128'h0);
    chk("reset_valid", {127'h0, rkey_valid}, 128'h0);
    chk("reset_busy", {127'h0, busy}, 128'h0);
    chk("reset_done", {127'h0, done}, 128'h0);
`ifdef KEY_STORE_EN
    chk("store_empty", rd_key, 128'h0);
`endif
    reset = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 A.1 schedule walked backwards
    for (int i = 0; i <= 10; i++) begin
      exp_key[i] = fips[i];
      exp_chk[i] = 1'b1;
    end
    push_run();
    lastkey = fips[10];
    start   = 1'b1;
    run_seq(0, 0, 0, 25, 1'b0, 128'h0);

`ifdef KEY_STORE_EN
    for (int i = 0; i <= 10; i++) begin
      rd_idx = 4'(i);
      #1;
      chk($sformatf("store_%0d", i), rd_key, fips[i]);
    end
    rd_idx = 4'd12;
    #1;
    chk("store_oob", rd_key, 128'h0);
`endif

    // extra starts while busy and in the done cycle are ignored
    push_run();
    start = 1'b1;
    run_seq(4, 21, 0, 25, 1'b0, 128'h0);

    // reset in the middle of a sequence
    push_run();
    start = 1'b1;
    run_seq(0, 0, 8, 25, 1'b0, 128'h0);

    // full rerun, then a back-to-back start right after done
    push_run();
    lastkey = fips[10];
    start   = 1'b1;
    run_seq(0, 0, 0, 21, 1'b1, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // all-zero cipher key walked back from its round-10 key
    for (int i = 0; i <= 10; i++) begin
      exp_key[i] = 128'h0;
      exp_chk[i] = 1'b0;
    end
    exp_key[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    exp_chk[10] = 1'b1;
    exp_key[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    exp_chk[2]  = 1'b1;
    exp_key[1]  = 128'h62636363626363636263636362636363;
    exp_chk[1]  = 1'b1;
    exp_key[0]  = 128'h0;
    exp_chk[0]  = 1'b1;
    push_run();
    run_seq(0, 0, 0, 25, 1'b0, 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
